// File: rtl/cbd_poly_collector.sv
// Collects 4-lane CBD(eta=2) sample words into one N-coefficient polynomial,
// reducing each lane into [0, Q-1] and holding the result for random-access readout.
module cbd_poly_collector #(
    parameter int Q  = 3329,
    parameter int N  = 256,
    parameter int CW = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [4*CW-1:0] in_data,
    output logic            in_ready,
    input  logic            clear,
    input  logic            rd_en,
    input  logic [7:0]      rd_addr,
    output logic [CW-1:0]   rd_data,
    output logic            poly_full,
    output logic [6:0]      word_cnt,
    output logic            range_err
);
    localparam int WORDS = N / 4;
    localparam int IW    = $clog2(WORDS);
    localparam int AW    = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    // Legal lanes are 0,1,2 and the two's-complement patterns of -1,-2; negatives wrap by +Q.
    function automatic logic [CW:0] reduce_lane(input logic [CW-1:0] lane);
        logic [CW:0] res;
        if (lane <= CW'(2)) begin
            res = {1'b0, lane};
        end else if (lane >= ({CW{1'b1}} - CW'(1))) begin
            res = {1'b0, CW'(lane + CW'(Q))};
        end else begin
            res = {1'b1, lane};
        end
        return res;
    endfunction

    state_t          state_r;
    state_t          state_s;
    logic [6:0]      word_cnt_r;
    logic            s1_valid_r;
    logic [4*CW-1:0] s1_data_r;
    logic [IW-1:0]   s1_idx_r;
    logic            range_err_r;
    logic [CW-1:0]   rd_data_r;
    logic [CW-1:0]   mem_r [N];

    logic            in_ready_s;
    logic            accept_s;
    logic            last_wr_s;
    logic [CW-1:0]   red_s [4];
    logic [3:0]      bad_s;

    assign in_ready_s = (state_r != ST_FULL) && (word_cnt_r < 7'(WORDS));
    assign accept_s   = in_valid && in_ready_s && !clear;
    assign last_wr_s  = s1_valid_r && (s1_idx_r == IW'(WORDS - 1));

    // Stage-2 lane reduction of the registered word
    always_comb begin
        bad_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            {bad_s[i], red_s[i]} = reduce_lane(s1_data_r[CW*i +: CW]);
        end
    end

    // Next-state decode; clear overrides every state
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) state_s = ST_FILL;
                    else          state_s = ST_IDLE;
                end
                ST_FILL: begin
                    if (last_wr_s) state_s = ST_FULL;
                    else           state_s = ST_FILL;
                end
                ST_FULL: state_s = ST_FULL;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Control, stage-1 capture, sticky error and read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            word_cnt_r  <= 7'd0;
            s1_valid_r  <= 1'b0;
            s1_data_r   <= '0;
            s1_idx_r    <= '0;
            range_err_r <= 1'b0;
            rd_data_r   <= '0;
        end else begin
            state_r <= state_s;
            if (clear) begin
                word_cnt_r  <= 7'd0;
                s1_valid_r  <= 1'b0;
                range_err_r <= 1'b0;
            end else begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    word_cnt_r <= word_cnt_r + 7'd1;
                    s1_data_r  <= in_data;
                    s1_idx_r   <= word_cnt_r[IW-1:0];
                end
                if (s1_valid_r && (bad_s != 4'b0000)) begin
                    range_err_r <= 1'b1;
                end
                if ((state_r == ST_FULL) && rd_en) begin
                    rd_data_r <= mem_r[rd_addr];
                end
            end
        end
    end

    // Coefficient array: no reset, reads are gated by FULL so stale data never escapes
    always_ff @(posedge clk) begin
        if (s1_valid_r && !clear) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[{s1_idx_r, 2'(i)}] <= red_s[i];
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign poly_full = (state_r == ST_FULL);
    assign word_cnt  = word_cnt_r;
    assign range_err = range_err_r;
    assign rd_data   = rd_data_r;

    logic unused_s;
    assign unused_s = ^{AW};

endmodule

// File: tb/tb_cbd_poly_collector.sv
// Scoreboard bench for cbd_poly_collector: stimulus steps a transaction-level model and
// queues expected outputs; a negedge monitor pops and compares them.
module tb_cbd_poly_collector;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_ready;
    logic        clear;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        poly_full;
    logic [6:0]  word_cnt;
    logic        range_err;

    cbd_poly_collector dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .poly_full(poly_full), .word_cnt(word_cnt),
        .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rd;
        bit          full;
        int          wc;
        bit          rdy;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   chk = 1'b0;
    bit   pend = 1'b0;

    // Reference model state
    logic [11:0] m_mem [256];
    int          m_wc;
    bit          m_full, m_err, m_pv;
    logic [11:0] m_rd;
    logic [47:0] m_pd;
    int          m_pidx;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_reduce(input logic [11:0] lane, output bit bad);
        int v;
        v = $signed(lane);
        bad = 1'b0;
        if (v >= 0 && v <= 2) return lane;
        if (v >= -2 && v <= -1) return 12'(3329 + v);
        bad = 1'b1;
        return lane;
    endfunction

    function automatic logic [47:0] rand_word();
        logic [47:0] w;
        int v;
        for (int i = 0; i < 4; i++) begin
            v = int'($urandom_range(0, 4)) - 2;
            w[12*i +: 12] = 12'(v);
        end
        return w;
    endfunction

    task automatic model_reset();
        m_wc = 0; m_full = 0; m_err = 0; m_pv = 0; m_rd = 12'd0; m_pidx = 0; m_pd = 48'd0;
    endtask

    // Effect of one clock edge with the given inputs on the model
    task automatic model_edge(input bit v, input logic [47:0] d, input bit clr,
                              input bit rden, input logic [7:0] addr);
        bit rdy, bad;
        rdy = !m_full && (m_wc < 64);
        if (clr) begin
            m_wc = 0; m_full = 0; m_err = 0; m_pv = 0;
        end else begin
            if (rden && m_full) m_rd = m_mem[addr];
            if (m_pv) begin
                for (int i = 0; i < 4; i++) begin
                    m_mem[m_pidx*4 + i] = ref_reduce(m_pd[12*i +: 12], bad);
                    if (bad) m_err = 1;
                end
                if (m_pidx == 63) m_full = 1;
            end
            m_pv = 0;
            if (v && rdy) begin
                m_pv = 1; m_pd = d; m_pidx = m_wc; m_wc++;
            end
        end
    endtask

    task automatic cyc(input bit v, input logic [47:0] d, input bit clr,
                       input bit rden, input logic [7:0] addr);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v; in_data = d; clear = clr; rd_en = rden; rd_addr = addr;
        model_edge(v, d, clr, rden, addr);
        e.rd = m_rd; e.full = m_full; e.wc = m_wc;
        e.rdy = !m_full && (m_wc < 64); e.err = m_err;
        exp_q.push_back(e);
        chk = 1'b1;
    endtask

    task automatic check_now(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_rd_data"}, int'(rd_data), 0);
        check({tag, "_poly_full"}, int'(poly_full), 0);
        check({tag, "_word_cnt"}, int'(word_cnt), 0);
        check({tag, "_range_err"}, int'(range_err), 0);
    endtask

    task automatic read_all();
        int a;
        a = 0;
        while (a < 256) begin
            if ($urandom_range(0, 3) != 0) begin
                cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'(a));
                a++;
            end else begin
                cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'($urandom));
            end
        end
    endtask

    task automatic fill_random_gaps(input logic [47:0] fixed, input bit use_fixed);
        while (m_wc < 64) begin
            cyc(1'($urandom_range(0, 2) != 0), use_fixed ? fixed : rand_word(), 1'b0,
                1'($urandom_range(0, 1)), 8'($urandom));
        end
    endtask

    // Monitor: one expectation per edge flagged by the stimulus
    always @(posedge clk) pend <= chk;

    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", int'(rd_data), int'(e.rd));
                check("poly_full", int'(poly_full), int'(e.full));
                check("word_cnt", int'(word_cnt), e.wc);
                check("in_ready", int'(in_ready), int'(e.rdy));
                check("range_err", int'(range_err), int'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        logic [47:0] w;
        reset = 1'b1; in_valid = 1'b0; in_data = 48'd0; clear = 1'b0;
        rd_en = 1'b0; rd_addr = 8'd0;
        model_reset();
        #1 check_now("reset");
        #13 reset = 1'b0;

        // Lanes {0,1,2,-1}, back-to-back
        for (int i = 0; i < 64; i++) cyc(1'b1, 48'hFFF002001000, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'd0);
        for (int a = 0; a < 4; a++) cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'(a));
        for (int i = 0; i < 6; i++) cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'($urandom));
        // New words while FULL are ignored
        for (int i = 0; i < 3; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0, 8'd0);
        for (int a = 0; a < 8; a++) cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'(a));
        // clear together with a read: read ignored
        cyc(1'b0, 48'd0, 1'b1, 1'b1, 8'd2);

        // All -2 lanes with random gaps, random reads during fill
        fill_random_gaps(48'hFFEFFEFFEFFE, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 48'h001001001001, 1'b0, 1'b0, 8'd0);
        read_all();
        cyc(1'b0, 48'd0, 1'b1, 1'b0, 8'd0);

        // Out-of-range lane at word 5, lane 2
        for (int i = 0; i < 64; i++) begin
            w = rand_word();
            if (i == 5) w[35:24] = 12'h003;
            cyc(1'b1, w, 1'b0, 1'b0, 8'd0);
        end
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'd22);
        cyc(1'b0, 48'd0, 1'b0, 1'b1, 8'd21);
        cyc(1'b0, 48'd0, 1'b1, 1'b0, 8'd0);

        // clear with in_valid on word 30, then a fresh fill
        for (int i = 0; i < 30; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0, 8'd0);
        cyc(1'b1, rand_word(), 1'b1, 1'b0, 8'd0);
        cyc(1'b1, rand_word(), 1'b0, 1'b0, 8'd0);
        fill_random_gaps(48'd0, 1'b0);
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'd0);
        read_all();
        cyc(1'b0, 48'd0, 1'b1, 1'b0, 8'd0);

        // Async reset at word_cnt=40, between edges
        for (int i = 0; i < 40; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'd0);
        @(posedge clk); #1 chk = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        model_reset();
        #1 check_now("async_reset");
        #1 reset = 1'b0;
        for (int i = 0; i < 64; i++) cyc(1'b1, rand_word(), 1'b0, 1'b0, 8'd0);
        cyc(1'b0, 48'd0, 1'b0, 1'b0, 8'd0);
        read_all();

        @(posedge clk); #1 chk = 1'b0;
        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
